// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writeback with
// out-of-band long-latency results held in a small FIFO, keeping WAW order.
module regfile_wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WbEnP,
  input  logic [4:0]      WbRdP,
  input  logic [XLEN-1:0] WbDataP,
  input  logic            LlValid,
  input  logic [4:0]      LlRd,
  input  logic [XLEN-1:0] LlData,
  output logic            LlReady,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  output logic            BusyRs1,
  output logic            BusyRs2,
  output logic            StallWB,
  output logic            RegWriteEnW,
  output logic [4:0]      RDW,
  output logic [XLEN-1:0] ResultW
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic [SW-1:0]   r_starve;

  logic w_pw, w_empty, w_head_vld, w_pw_grant, w_head_grant;
  logic w_pop, w_push, w_push_vld;

  // A slot's valid bit is cleared on pop, so r_vld alone marks live,
  // un-killed entries and the head bit is meaningful even when empty.
  assign w_pw         = WbEnP && (WbRdP != 5'd0);
  assign w_empty      = (r_count == '0);
  assign w_head_vld   = r_vld[r_rptr];
  assign StallWB      = (r_starve == STARVE_LIM) && w_head_vld;
  assign LlReady      = (r_count != FULL_CNT);
  assign w_pw_grant   = w_pw && !StallWB;
  assign w_head_grant = StallWB || (!w_pw && w_head_vld);
  assign w_pop        = !w_empty && (StallWB || !w_pw);
  assign w_push       = LlValid && LlReady && (LlRd != 5'd0);
  assign w_push_vld   = !(w_pw_grant && (WbRdP == LlRd));

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    BusyRs1 = 1'b0;
    BusyRs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_rd[i] == Rs1D) && (Rs1D != 5'd0)) BusyRs1 = 1'b1;
      if (r_vld[i] && (r_rd[i] == Rs2D) && (Rs2D != 5'd0)) BusyRs2 = 1'b1;
    end
  end

  // NOTE: the payload array carries no reset; an entry is only ever read
  // while its valid bit (which is reset) says it holds something.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= LlRd;
      r_data[r_wptr] <= LlData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every process
  // sees pre-edge values; later assignments to the same bit win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      RegWriteEnW <= 1'b0;
      RDW         <= '0;
      ResultW     <= '0;
    end else begin
      if (w_pw_grant) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd[i] == WbRdP) r_vld[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      if (w_push) begin
        r_vld[r_wptr] <= w_push_vld;
        r_wptr        <= r_wptr + AW'(1);
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

      if (w_pop || w_empty)  r_starve <= '0;
      else if (w_head_vld)   r_starve <= r_starve + SW'(1);

      RegWriteEnW <= w_pw_grant || w_head_grant;
      if (w_pw_grant) begin
        RDW     <= WbRdP;
        ResultW <= WbDataP;
      end else if (w_head_grant) begin
        RDW     <= r_rd[r_rptr];
        ResultW <= r_data[r_rptr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model
// predicts writes and handshake/busy flags; a monitor checks each write.
module tb_regfile_wb_arbiter;

  localparam int XLEN       = 64;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            WbEnP = 1'b0;
  logic [4:0]      WbRdP = '0;
  logic [XLEN-1:0] WbDataP = '0;
  logic            LlValid = 1'b0;
  logic [4:0]      LlRd = '0;
  logic [XLEN-1:0] LlData = '0;
  logic            LlReady;
  logic [4:0]      Rs1D = '0;
  logic [4:0]      Rs2D = '0;
  logic            BusyRs1, BusyRs2, StallWB, RegWriteEnW;
  logic [4:0]      RDW;
  logic [XLEN-1:0] ResultW;

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .WbEnP(WbEnP), .WbRdP(WbRdP), .WbDataP(WbDataP),
    .LlValid(LlValid), .LlRd(LlRd), .LlData(LlData), .LlReady(LlReady),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .BusyRs1(BusyRs1), .BusyRs2(BusyRs2),
    .StallWB(StallWB), .RegWriteEnW(RegWriteEnW), .RDW(RDW), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; bit vld; } ent_t;
  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } wr_t;

  ent_t m_q[$];       // reference FIFO contents, oldest first
  wr_t  exp_q[$];     // scoreboard of expected register-file writes
  int   m_starve = 0;
  bit   m_last_stall = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare flags against the model, then
  // advance the model by the arbitration rules and queue the predicted write.
  task automatic step(input bit en, input logic [4:0] rd, input logic [XLEN-1:0] data,
                      input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldata,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    bit stall, ready, pw, b1, b2, popped, head_vld, was_empty;
    @(negedge clk);
    WbEnP = en; WbRdP = rd; WbDataP = data;
    LlValid = lv; LlRd = lrd; LlData = ldata;
    Rs1D = rs1; Rs2D = rs2;
    #1;
    was_empty = (m_q.size() == 0);
    head_vld  = !was_empty && m_q[0].vld;
    stall = (m_starve == STARVE_MAX) && head_vld;
    ready = (m_q.size() < DEPTH);
    b1 = 0; b2 = 0;
    foreach (m_q[i]) begin
      if (m_q[i].vld && m_q[i].rd == rs1 && rs1 != 0) b1 = 1;
      if (m_q[i].vld && m_q[i].rd == rs2 && rs2 != 0) b2 = 1;
    end
    check("stall_wb", StallWB, stall);
    check("ll_ready", LlReady, ready);
    check("busy_rs1", BusyRs1, b1);
    check("busy_rs2", BusyRs2, b2);

    pw = en && (rd != 0) && !stall;
    popped = 0;
    if (stall) begin
      exp_q.push_back('{m_q[0].rd, m_q[0].data});
      void'(m_q.pop_front());
      popped = 1;
    end else if (pw) begin
      exp_q.push_back('{rd, data});
      foreach (m_q[i]) if (m_q[i].rd == rd) m_q[i].vld = 0;
    end else if (!was_empty) begin
      if (m_q[0].vld) exp_q.push_back('{m_q[0].rd, m_q[0].data});
      void'(m_q.pop_front());
      popped = 1;
    end
    if (lv && ready && lrd != 0) m_q.push_back('{lrd, ldata, !(pw && rd == lrd)});

    if (popped || was_empty) m_starve = 0;
    else if (head_vld)       m_starve++;
    m_last_stall = stall;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: each edge either presents the oldest expected write or none.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (RegWriteEnW) begin
          if (exp_q.size() == 0) begin
            check("spurious_write", RegWriteEnW, 1'b0);
          end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("write_rd", RDW, w.rd);
            check("write_data", ResultW, w.data);
          end
        end else if (exp_q.size() > 0) begin
          check("missing_write", RegWriteEnW, 1'b1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int stall_at;
    logic [4:0] h_rd; logic [XLEN-1:0] h_data; bit h_en;

    #2;
    check("rst_wen", RegWriteEnW, 1'b0);
    check("rst_rdw", RDW, 5'd0);
    check("rst_result", ResultW, 64'd0);
    check("rst_stall", StallWB, 1'b0);
    check("rst_ready", LlReady, 1'b1);
    check("rst_busy1", BusyRs1, 1'b0);
    @(negedge clk); #2 rst = 1'b0;

    // Single long-latency result, no pipeline traffic.
    step(0, 0, 0, 1, 5, 64'h11, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);

    // Starvation under continuous pipeline writes to x3.
    stall_at = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1, 3, 64'h300 + 64'(k), k == 1, 7, 64'h77, 7, 3);
      if (m_last_stall && stall_at == 0) stall_at = k;
    end
    check("starve_cycle", 64'(stall_at), 64'd10);
    idle(2);

    // WAW: queued x9 is superseded by a newer pipeline write.
    step(1, 3, 64'h1, 1, 9, 64'h99, 9, 0);
    step(1, 9, 64'hAA, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    idle(2);

    // Fill to full behind pipeline traffic, then drain in order.
    for (int k = 0; k < 5; k++) step(1, 3, 64'h500 + 64'(k), k < 4, 5'(10 + k), 64'hB0 + 64'(k), 12, 13);
    idle(6);

    // x0 destinations never reach the port.
    step(1, 0, 64'hDEAD, 1, 0, 64'hBEEF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Asynchronous reset with three entries pending.
    for (int k = 0; k < 3; k++) step(1, 3, 64'h600, 1, 5'(20 + k), 64'hC0, 20, 21);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_wen", RegWriteEnW, 1'b0);
    check("mid_rst_ready", LlReady, 1'b1);
    check("mid_rst_busy1", BusyRs1, 1'b0);
    check("mid_rst_busy2", BusyRs2, 1'b0);
    m_q.delete(); exp_q.delete(); m_starve = 0; m_last_stall = 0;
    WbEnP = 0; LlValid = 0;
    @(negedge clk); rst = 1'b0;
    idle(4);

    // Randomised traffic on a narrow register range to provoke collisions.
    h_en = 0; h_rd = 0; h_data = 0;
    for (int k = 0; k < 500; k++) begin
      if (!m_last_stall) begin
        h_en   = ($urandom_range(0, 99) < 60);
        h_rd   = 5'($urandom_range(0, 7));
        h_data = {$urandom, $urandom};
      end
      step(h_en, h_rd, h_data, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
           {$urandom, $urandom}, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(12);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port (RegWriteEnW/RDW/ResultW) between two sources:
  - the in-order pipeline writeback;
  - a long-latency unit (multiply/divide) that completes out of band.
- Buffers long-latency results in a small FIFO and enforces write-after-write ordering against later pipeline writes.
- Requests a one-cycle writeback freeze when the FIFO is starved.
- Exports per-register busy flags so decode hazard logic can stall readers of pending destinations.

Parameters:
- XLEN, 64, data width of results.
- DEPTH, 4, long-latency result FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive deferred cycles before a forced drain.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- WbEnP  input  1  pipeline writeback valid.
- WbRdP  input  5  pipeline destination register.
- WbDataP  input  XLEN  pipeline writeback data.
- LlValid  input  1  long-latency result valid.
- LlRd  input  5  long-latency destination register.
- LlData  input  XLEN  long-latency result data.
- LlReady  output  1  FIFO can accept; equals ~full.
- Rs1D  input  5  decode source 1, for busy check.
- Rs2D  input  5  decode source 2, for busy check.
- BusyRs1  output  1  a valid FIFO entry targets Rs1D (Rs1D != 0).
- BusyRs2  output  1  a valid FIFO entry targets Rs2D (Rs2D != 0).
- StallWB  output  1  freeze MEM/WB this cycle (forced drain).
- RegWriteEnW  output  1  register-file write enable, registered.
- RDW  output  5  register-file write address, registered.
- ResultW  output  XLEN  register-file write data, registered.

Behaviour:
- Reset: RegWriteEnW=0, RDW=0, ResultW=0, StallWB=0, FIFO empty, all entry valid bits 0, starve counter 0. After reset, LlReady=1 and BusyRs1=BusyRs2=0.
- Effective pipeline write (PW) = WbEnP && WbRdP != 0. Writes to x0 never use the port.
- Enqueue:
  - On LlValid && LlReady, push {LlRd, LlData, valid}.
  - If LlRd == 0, the result is discarded; nothing is pushed and the handshake still completes.
  - If PW in the same cycle has WbRdP == LlRd, the entry is pushed with valid=0 (killed).
- Kill: each cycle with a granted PW, every FIFO entry with matching rd has its valid bit cleared (WAW ordering; the pipeline write is newer).
- Grant priority per cycle:
  - Forced drain (StallWB=1): FIFO head is granted; pipeline inputs are ignored because the frozen stage re-presents them next cycle.
  - Otherwise, if PW: the pipeline is granted.
  - Otherwise, if head valid: the head is granted and popped.
  - Otherwise, if head invalid (killed): the head is popped without a write.
  - At most one pop per cycle.
- Output timing: the granted write appears on RegWriteEnW/RDW/ResultW at the next rising edge (latency 1). With no grant, RegWriteEnW=0; RDW/ResultW hold their previous values.
- Starvation:
  - Counter increments each cycle the head is valid and not granted; it clears on any head pop or when the FIFO is empty.
  - StallWB = (counter == STARVE_MAX) && head valid. It is a combinational output of registered state, high for exactly one cycle; the counter clears on that cycle's pop.
- Full: LlReady=0 when count == DEPTH. A pop and a push in the same cycle while full are not allowed (LlReady already low).
- Empty: no pop. Killed entries still occupy slots until popped.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Count is tracked with log2(DEPTH)+1 bits.
- Busy flags: combinational over valid entries only. A value arriving in the current cycle is not included.
- Reset mid-operation: all pending entries are lost, and outputs return to reset values asynchronously.

Test Plan:
- Reset, then LlValid with LlRd=5, LlData=0x11, no PW → BusyRs1=1 for Rs1D=5 for one cycle. Next edge: RegWriteEnW=1, RDW=5, ResultW=0x11. Then BusyRs1=0.
- PW to x3 every cycle, one Ll entry to x7 → StallWB=1 on exactly the 9th cycle of deferral (STARVE_MAX=8). Following edge writes x7; counter reads 0.
- Ll entry to x9 queued, then PW to x9 with 0xAA → x9 is written once with 0xAA. The queued entry is popped silently and BusyRs1(Rs1D=9)=0 after the PW.
- Push 4 entries while PW is continuous → LlReady=0 after the 4th. Drop PW → one pop per cycle, and LlReady=1 the cycle after the first pop. FIFO order is preserved across pointer wrap.
- LlRd=0 and WbRdP=0 writes → no RegWriteEnW pulse, count unchanged.
- Assert rst with 3 entries pending → RegWriteEnW=0, LlReady=1, BusyRs*=0 immediately; no writes after release.
